// File: rtl/rom_loader_pkg.sv
// Shared definitions for the instruction-RAM loader: FSM state encoding,
// instruction width and frame byte counts.
// Optional feature macro: ROM_LOADER_CHECKSUM_EN (adds the CHK state).
package rom_loader_pkg;

  localparam int INSTR_WIDTH = 28;
  localparam int LEN_BYTES   = 2;
  localparam int WORD_BYTES  = 4;
  localparam int LEN_WIDTH   = 8 * LEN_BYTES;

  // Explicit encodings keep the state values stable across both builds.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    ST_CHK    = 3'd4
`endif
  } state_e;

  // States in which the loader consumes stream bytes.
  function automatic logic takes_bytes(input state_e s);
    logic r;
    r = (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA);
`ifdef ROM_LOADER_CHECKSUM_EN
    r = r || (s == ST_CHK);
`endif
    return r;
  endfunction

endpackage

// File: rtl/rom_loader_instr_assembler.sv
// Collects four stream bytes into one instruction word. Only the low 20 bits
// of the first three bytes are kept, since the top nibble of the first byte
// is discarded; the word is completed combinationally with the fourth byte.
module rom_loader_instr_assembler
  import rom_loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic [7:0]             byte_i,
  output logic                   word_done_o,
  output logic [INSTR_WIDTH-1:0] word_o
);

  localparam int HELD_BITS = INSTR_WIDTH - 8;

  logic [1:0]           cnt_q;
  logic [HELD_BITS-1:0] held_q;

  assign word_done_o = push_i && (cnt_q == 2'(WORD_BYTES - 1));
  assign word_o      = {held_q, byte_i};

  // Byte position counter and partial-word shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state updates use <= so every flop samples pre-edge values.
      cnt_q  <= '0;
      held_q <= '0;
    end else if (clear_i) begin
      cnt_q  <= '0;
      held_q <= '0;
    end else if (push_i) begin
      cnt_q  <= cnt_q + 2'd1;
      held_q <= HELD_BITS'({held_q, byte_i});
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Writer side of the instruction memory: receives a length-prefixed byte
// stream, assembles 28-bit instructions, writes them to sequential RAM
// addresses and keeps the core in reset until the program is complete.
// Optional feature macro: ROM_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 256
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iStart,
  input  logic                   iByteValid,
  input  logic [7:0]             iByte,
  output logic                   oByteReady,
  output logic                   oWriteEnable,
  output logic [ADDR_WIDTH-1:0]  oWriteAddress,
  output logic [INSTR_WIDTH-1:0] oWriteData,
  output logic                   oCpuReset,
  output logic                   oDone,
  output logic                   oError
);

  localparam logic [LEN_WIDTH-1:0] DEPTH_N = LEN_WIDTH'(DEPTH);

`ifdef ROM_LOADER_CHECKSUM_EN
  localparam state_e AFTER_DATA = ST_CHK;
`else
  localparam state_e AFTER_DATA = ST_DONE;
`endif

  state_e                 state_q, state_d;
  logic                   byte_ready_q, byte_ready_d;
  logic                   write_en_q, write_en_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [INSTR_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                   cpu_reset_q, cpu_reset_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;

  logic [7:0]             len_hi_q;
  logic [LEN_WIDTH-1:0]   len_last_q;
  logic [ADDR_WIDTH-1:0]  addr_q;

  logic                   accept;
  logic                   start_ok;
  logic [LEN_WIDTH-1:0]   len_n;
  logic                   word_done;
  logic [INSTR_WIDTH-1:0] word;
  logic                   last_word;

  assign accept    = iByteValid && byte_ready_q;
  assign start_ok  = iStart && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                (state_q == ST_ERROR));
  assign len_n     = {len_hi_q, iByte};
  assign last_word = word_done && (addr_q == ADDR_WIDTH'(len_last_q));

  rom_loader_instr_assembler u_asm (
    .clk        (Clock),
    .rst_n      (Reset),
    .clear_i    (start_ok),
    .push_i     (accept && (state_q == ST_DATA)),
    .byte_i     (iByte),
    .word_done_o(word_done),
    .word_o     (word)
  );

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0] acc_q;

  // Running XOR over every accepted length and data byte.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      acc_q <= '0;
    end else if (start_ok) begin
      acc_q <= '0;
    end else if (accept && (state_q != ST_CHK)) begin
      acc_q <= acc_q ^ iByte;
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch forms.
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (iStart) state_d = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (accept) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (accept) begin
          if (len_n > DEPTH_N)   state_d = ST_ERROR;
          else if (len_n == '0)  state_d = AFTER_DATA;
          else                   state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (last_word) state_d = AFTER_DATA;
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (accept) state_d = (iByte == acc_q) ? ST_DONE : ST_ERROR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output decode into next values of the registered outputs. oDone
  // follows DONE one cycle late, which keeps it clear of the final write
  // strobe, and drops on the same edge that honours an iStart from DONE.
  always_comb begin
    byte_ready_d = takes_bytes(state_d);
    done_d       = (state_q == ST_DONE) && !iStart;
    cpu_reset_d  = !done_d;
    error_d      = (state_d == ST_ERROR);
    write_en_d   = word_done;
    wr_addr_d    = word_done ? addr_q : wr_addr_q;
    wr_data_d    = word_done ? word   : wr_data_q;
  end

  // Registered outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      byte_ready_q <= 1'b0;
      write_en_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      byte_ready_q <= byte_ready_d;
      write_en_q   <= write_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cpu_reset_q  <= cpu_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  // Length capture and write address counter; the counter advances at the
  // end of each strobe so it equals the index of the word being assembled.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      len_hi_q   <= '0;
      len_last_q <= '0;
      addr_q     <= '0;
    end else begin
      if ((state_q == ST_LEN_HI) && accept) len_hi_q <= iByte;
      if ((state_q == ST_LEN_LO) && accept) len_last_q <= len_n - LEN_WIDTH'(1);
      if (start_ok)        addr_q <= '0;
      else if (write_en_q) addr_q <= addr_q + ADDR_WIDTH'(1);
    end
  end

  assign oByteReady    = byte_ready_q;
  assign oWriteEnable  = write_en_q;
  assign oWriteAddress = wr_addr_q;
  assign oWriteData    = wr_data_q;
  assign oCpuReset     = cpu_reset_q;
  assign oDone         = done_q;
  assign oError        = error_q;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader. Expected RAM writes are queued as each
// word's last byte is driven and compared when the write strobe appears.
// Honours ROM_LOADER_CHECKSUM_EN to append checksum bytes and run the
// bad-checksum case.
module tb_rom_loader;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        iStart;
  logic        iByteValid;
  logic [7:0]  iByte;
  logic        oByteReady;
  logic        oWriteEnable;
  logic [15:0] oWriteAddress;
  logic [27:0] oWriteData;
  logic        oCpuReset;
  logic        oDone;
  logic        oError;

  rom_loader #(.ADDR_WIDTH(16), .DEPTH(256)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iStart       (iStart),
    .iByteValid   (iByteValid),
    .iByte        (iByte),
    .oByteReady   (oByteReady),
    .oWriteEnable (oWriteEnable),
    .oWriteAddress(oWriteAddress),
    .oWriteData   (oWriteData),
    .oCpuReset    (oCpuReset),
    .oDone        (oDone),
    .oError       (oError)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [15:0] addr;
    logic [27:0] data;
  } wr_t;

  int          n_checks = 0;
  int          n_errors = 0;
  wr_t         exp_q[$];
  wr_t         exp_w;
  logic [31:0] prog[$];
  int          writes_seen = 0;
  logic        prev_done = 1'b0;
  logic        prev_cpu  = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write-strobe scoreboard and release-timing monitor.
  always @(negedge Clock) begin
    if (Reset) begin
      if (oWriteEnable) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(oWriteAddress), 32'hFFFF_FFFF);
        end else begin
          exp_w = exp_q.pop_front();
          check("wr_addr", 32'(oWriteAddress), 32'(exp_w.addr));
          check("wr_data", 32'(oWriteData), 32'(exp_w.data));
        end
      end
      if (oDone && !prev_done) begin
        check("cpu_rst_before_done", 32'(prev_cpu), 1);
        check("cpu_rst_at_done", 32'(oCpuReset), 0);
        check("no_strobe_at_done", 32'(oWriteEnable), 0);
      end
    end
    prev_done = oDone;
    prev_cpu  = oCpuReset;
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit took = 1'b0;
    for (int n = 0; n < 64 && !took; n++) begin
      @(negedge Clock);
      iStart = 1'b0;
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        iByteValid = 1'b0;
        iByte      = 8'($urandom);
      end else begin
        iByteValid = 1'b1;
        iByte      = b;
        took       = oByteReady;
      end
    end
    if (!took) check("byte_accept_timeout", 0, 1);
  endtask

  task automatic do_load(input logic [15:0] n, input bit gaps, input bit stray_start,
                         input bit bad_chk, input bit expect_ok, input string name);
    logic [7:0]  acc;
    logic [31:0] w;
    logic [7:0]  b;
    int          w0;
    int          exp_writes;
    acc        = 8'h00;
    w0         = writes_seen;
    exp_writes = (n <= 16'd256) ? int'(n) : 0;
    @(negedge Clock);
    iStart     = 1'b1;
    iByteValid = 1'b0;
    send_byte(n[15:8], gaps); acc ^= n[15:8];
    send_byte(n[7:0], gaps);  acc ^= n[7:0];
    if (n <= 16'd256) begin
      for (int i = 0; i < int'(n); i++) begin
        w = prog[i];
        for (int k = 0; k < 4; k++) begin
          b = w[31 - 8*k -: 8];
          if (k == 3) exp_q.push_back({16'(i), w[27:0]});
          send_byte(b, gaps);
          acc ^= b;
          if (stray_start && i == 1 && k == 0) begin
            @(negedge Clock);
            iStart     = 1'b1;
            iByteValid = 1'b0;
          end
        end
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      send_byte(acc ^ (bad_chk ? 8'h01 : 8'h00), gaps);
`endif
    end
    @(negedge Clock);
    iStart     = 1'b0;
    iByteValid = 1'b0;
    for (int t = 0; t < 20 && !(oDone || oError); t++) @(negedge Clock);
    @(negedge Clock);
    check({name, "_done"},     32'(oDone),      32'(expect_ok));
    check({name, "_error"},    32'(oError),     32'(!expect_ok));
    check({name, "_cpu_rst"},  32'(oCpuReset),  32'(!expect_ok));
    check({name, "_ready"},    32'(oByteReady), 0);
    check({name, "_sb_empty"}, 32'(exp_q.size()), 0);
    check({name, "_writes"},   32'(writes_seen - w0), 32'(exp_writes));
  endtask

  initial begin
    Reset      = 1'b1;
    iStart     = 1'b0;
    iByteValid = 1'b0;
    iByte      = 8'h00;
    #2 Reset = 1'b0;
    #10;
    check("rst_ready",   32'(oByteReady),    0);
    check("rst_we",      32'(oWriteEnable),  0);
    check("rst_addr",    32'(oWriteAddress), 0);
    check("rst_data",    32'(oWriteData),    0);
    check("rst_cpu_rst", 32'(oCpuReset),     1);
    check("rst_done",    32'(oDone),         0);
    check("rst_error",   32'(oError),        0);
    @(negedge Clock);
    Reset = 1'b1;

    prog = {32'h0A112233, 32'h0B445566, 32'h0C778899};
    do_load(16'd3, 1'b0, 1'b0, 1'b0, 1'b1, "n3");

    do_load(16'd0, 1'b0, 1'b0, 1'b0, 1'b1, "n0");

    do_load(16'd257, 1'b0, 1'b0, 1'b0, 1'b0, "n257");
    @(negedge Clock);
    iStart = 1'b1;
    @(negedge Clock);
    iStart = 1'b0;
    check("restart_error_cleared", 32'(oError),     0);
    check("restart_cpu_rst",       32'(oCpuReset),  1);
    check("restart_ready",         32'(oByteReady), 1);
    // Loader now sits in LEN_HI; the start pulse of this load is ignored.
    do_load(16'd3, 1'b0, 1'b0, 1'b0, 1'b1, "after_err");

`ifdef ROM_LOADER_CHECKSUM_EN
    prog = {32'h01020304};
    do_load(16'd1, 1'b0, 1'b0, 1'b1, 1'b0, "bad_chk");
`endif

    prog = {32'h0A112233, 32'h0B445566, 32'h0C778899};
    do_load(16'd3, 1'b1, 1'b1, 1'b0, 1'b1, "gaps");

    // Reset in the middle of word 1.
    @(negedge Clock);
    iStart     = 1'b1;
    iByteValid = 1'b0;
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) exp_q.push_back({16'd0, 28'hA112233});
      send_byte(prog[0][31 - 8*k -: 8], 1'b0);
    end
    send_byte(8'h0B, 1'b0);
    send_byte(8'h44, 1'b0);
    @(negedge Clock);
    iByteValid = 1'b1;
    iByte      = 8'h55;
    #1 Reset = 1'b0;
    #1;
    check("midrst_ready",    32'(oByteReady),   0);
    check("midrst_we",       32'(oWriteEnable), 0);
    check("midrst_cpu_rst",  32'(oCpuReset),    1);
    check("midrst_done",     32'(oDone),        0);
    check("midrst_sb_empty", 32'(exp_q.size()), 0);
    repeat (3) @(negedge Clock);
    iByteValid = 1'b0;
    Reset      = 1'b1;
    do_load(16'd3, 1'b0, 1'b0, 1'b0, 1'b1, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
